// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, zero-register address and types
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester handshake plus registered register-file write port
interface regfile_wr_arbiter_if import regfile_pkg::*; #(
  parameter int NREQ = 3,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [IW-1:0] gnt_id;
  modport master (output req_valid, req_addr, req_data, input req_ready, we3, wa3, wd3, gnt_id);
  modport slave (input req_valid, req_addr, req_data, output req_ready, we3, wa3, wd3, gnt_id);
endinterface

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder, first set request at or after ptr wins
module rr_picker #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    int j;
    j = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the regfile write port with a registered output stage
// REGFILE_ARB_STATS_EN adds per-requester saturating grant counters on grant_cnt.
module regfile_wr_arbiter import regfile_pkg::*; #(
  parameter int NREQ = 3,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input logic clk,
  input logic reset,
  input logic stall,
  regfile_wr_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  , output logic [NREQ*16-1:0] grant_cnt
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] idx, ptr_q, ptr_d, gnt_id_q, gnt_id_d;
  logic any, xfer, we3_q, we3_d;
  logic [AW-1:0] addr, wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  rr_picker #(.N(NREQ), .IW(IW)) u_pick (
    .req_i(bus.req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx),
    .any_o(any)
  );
  always_comb begin
    xfer = any && !stall && !reset;
    addr = bus.req_addr[idx*AW +: AW];
    bus.req_ready = xfer ? gnt : '0;
    ptr_d = !xfer ? ptr_q : (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
    // r0 is hardwired zero: accept the write but never strobe the regfile
    we3_d = xfer && (addr != AW'(REG_ZERO));
    wa3_d = xfer ? addr : wa3_q;
    wd3_d = xfer ? bus.req_data[idx*DW +: DW] : wd3_q;
    gnt_id_d = xfer ? idx : gnt_id_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
      gnt_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
      gnt_id_q <= gnt_id_d;
    end
  end
  assign bus.we3 = we3_q;
  assign bus.wa3 = wa3_q;
  assign bus.wd3 = wd3_q;
  assign bus.gnt_id = gnt_id_q;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset) cnt_q[i] <= '0;
      else if (xfer && idx == IW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
    assign grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif
endmodule
